// File: rtl/alu_pkg.sv
// Shared encodings for the execute stage: ALU operation codes, branch
// condition selects and forwarding-mux selects.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_AND   = 4'b0010,
    ALU_OR    = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SLT   = 4'b0101,
    ALU_SLTU  = 4'b0110,
    ALU_SLL   = 4'b0111,
    ALU_SRL   = 4'b1000,
    ALU_SRA   = 4'b1001,
    ALU_PASSB = 4'b1010
  } alu_op_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/execute_stage_if.sv
// Signal bundle around the execute stage: E-side inputs from the decode/execute
// register and hazard unit, and the redirect plus M-side outputs.
interface execute_stage_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, JalrE;
  logic [1:0]            ResultSrcE;
  logic [3:0]            ALUControlE;
  logic [2:0]            funct3E;
  logic [XLEN-1:0]       rs1_data_E, rs2_data_E, PCE, immExtE, PCPlus4E;
  logic [REG_ADDR_W-1:0] RdE;
  logic [1:0]            ForwardAE, ForwardBE;
  logic [XLEN-1:0]       ResultW;

  logic                  PCSrcE;
  logic [XLEN-1:0]       PCTargetE;
  logic                  RegWriteM, MemWriteM;
  logic [1:0]            ResultSrcM;
  logic [XLEN-1:0]       ALUResultM, WriteDataM, PCPlus4M;
  logic [REG_ADDR_W-1:0] RdM;

  // Upstream (decode/hazard/writeback) drives the E side and observes the rest.
  modport master (
    output RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, JalrE, ResultSrcE,
           ALUControlE, funct3E, rs1_data_E, rs2_data_E, PCE, immExtE, PCPlus4E,
           RdE, ForwardAE, ForwardBE, ResultW,
    input  PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, ALUResultM,
           WriteDataM, PCPlus4M, RdM
  );

  modport slave (
    input  RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, JalrE, ResultSrcE,
           ALUControlE, funct3E, rs1_data_E, rs2_data_E, PCE, immExtE, PCPlus4E,
           RdE, ForwardAE, ForwardBE, ResultW,
    output PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, ALUResultM,
           WriteDataM, PCPlus4M, RdM
  );
endinterface

// File: rtl/alu.sv
// Combinational RV32I ALU. Shifts use only the low five bits of src_b;
// unassigned operation codes yield zero.
module alu
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic [3:0]      alu_ctrl,
  output logic [XLEN-1:0] result
);

  logic [4:0] shamt;

  always_comb begin
    shamt  = src_b[4:0];
    result = '0;
    case (alu_ctrl)
      ALU_ADD:   result = src_a + src_b;
      ALU_SUB:   result = src_a - src_b;
      ALU_AND:   result = src_a & src_b;
      ALU_OR:    result = src_a | src_b;
      ALU_XOR:   result = src_a ^ src_b;
      ALU_SLT:   result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      ALU_SLTU:  result = {{(XLEN-1){1'b0}}, (src_a < src_b)};
      ALU_SLL:   result = src_a << shamt;
      ALU_SRL:   result = src_a >> shamt;
      ALU_SRA:   result = $unsigned($signed(src_a) >>> shamt);
      ALU_PASSB: result = src_b;
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// RV32I execute stage: operand forwarding, ALU, branch/jump resolution with a
// combinational redirect to fetch, and the execute/memory pipeline register.
module execute_stage
  import alu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  RegWriteE,
  input  logic                  MemWriteE,
  input  logic                  JumpE,
  input  logic                  BranchE,
  input  logic                  ALUSrcE,
  input  logic                  JalrE,
  input  logic [1:0]            ResultSrcE,
  input  logic [3:0]            ALUControlE,
  input  logic [2:0]            funct3E,
  input  logic [XLEN-1:0]       rs1_data_E,
  input  logic [XLEN-1:0]       rs2_data_E,
  input  logic [XLEN-1:0]       PCE,
  input  logic [XLEN-1:0]       immExtE,
  input  logic [XLEN-1:0]       PCPlus4E,
  input  logic [REG_ADDR_W-1:0] RdE,
  input  logic [1:0]            ForwardAE,
  input  logic [1:0]            ForwardBE,
  input  logic [XLEN-1:0]       ResultW,
  output logic                  PCSrcE,
  output logic [XLEN-1:0]       PCTargetE,
  output logic                  RegWriteM,
  output logic                  MemWriteM,
  output logic [1:0]            ResultSrcM,
  output logic [XLEN-1:0]       ALUResultM,
  output logic [XLEN-1:0]       WriteDataM,
  output logic [XLEN-1:0]       PCPlus4M,
  output logic [REG_ADDR_W-1:0] RdM
);

  logic [XLEN-1:0]       src_a, fwd_b, src_b, alu_result, jalr_sum;
  logic                  taken, eq, lt, ltu;

  logic                  reg_write_d, reg_write_q;
  logic                  mem_write_d, mem_write_q;
  logic [1:0]            result_src_d, result_src_q;
  logic [XLEN-1:0]       alu_result_d, alu_result_q;
  logic [XLEN-1:0]       write_data_d, write_data_q;
  logic [XLEN-1:0]       pc_plus4_d, pc_plus4_q;
  logic [REG_ADDR_W-1:0] rd_d, rd_q;

  // The MEM-stage operand comes straight from our own register, so the
  // feedback path is register-to-mux and loop-free.
  always_comb begin
    src_a = rs1_data_E;
    case (ForwardAE)
      FWD_WB:  src_a = ResultW;
      FWD_MEM: src_a = alu_result_q;
      default: src_a = rs1_data_E;
    endcase
    fwd_b = rs2_data_E;
    case (ForwardBE)
      FWD_WB:  fwd_b = ResultW;
      FWD_MEM: fwd_b = alu_result_q;
      default: fwd_b = rs2_data_E;
    endcase
    src_b = ALUSrcE ? immExtE : fwd_b;
  end

  alu #(.XLEN(XLEN)) u_alu (
    .src_a    (src_a),
    .src_b    (src_b),
    .alu_ctrl (ALUControlE),
    .result   (alu_result)
  );

  // Branches compare against the forwarded rs2, never the immediate.
  always_comb begin
    eq    = (src_a == fwd_b);
    lt    = ($signed(src_a) < $signed(fwd_b));
    ltu   = (src_a < fwd_b);
    taken = 1'b0;
    case (funct3E)
      F3_BEQ:  taken = eq;
      F3_BNE:  taken = !eq;
      F3_BLT:  taken = lt;
      F3_BGE:  taken = !lt;
      F3_BLTU: taken = ltu;
      F3_BGEU: taken = !ltu;
      default: taken = 1'b0;
    endcase
    jalr_sum  = src_a + immExtE;
    PCSrcE    = JumpE | (BranchE & taken);
    PCTargetE = JalrE ? {jalr_sum[XLEN-1:1], 1'b0} : (PCE + immExtE);
  end

  always_comb begin
    reg_write_d  = RegWriteE;
    mem_write_d  = MemWriteE;
    result_src_d = ResultSrcE;
    alu_result_d = alu_result;
    write_data_d = fwd_b;
    pc_plus4_d   = PCPlus4E;
    rd_d         = RdE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      result_src_q <= '0;
      alu_result_q <= '0;
      write_data_q <= '0;
      pc_plus4_q   <= '0;
      rd_q         <= '0;
    end else begin
      reg_write_q  <= reg_write_d;
      mem_write_q  <= mem_write_d;
      result_src_q <= result_src_d;
      alu_result_q <= alu_result_d;
      write_data_q <= write_data_d;
      pc_plus4_q   <= pc_plus4_d;
      rd_q         <= rd_d;
    end
  end

  assign RegWriteM  = reg_write_q;
  assign MemWriteM  = mem_write_q;
  assign ResultSrcM = result_src_q;
  assign ALUResultM = alu_result_q;
  assign WriteDataM = write_data_q;
  assign PCPlus4M   = pc_plus4_q;
  assign RdM        = rd_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed plus randomized bench for execute_stage, checked against a
// behavioural model of the RV32I execute rules.
module tb_execute_stage;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  execute_stage_if #(.XLEN(32), .REG_ADDR_W(5)) ex ();

  execute_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .RegWriteE   (ex.RegWriteE),
    .MemWriteE   (ex.MemWriteE),
    .JumpE       (ex.JumpE),
    .BranchE     (ex.BranchE),
    .ALUSrcE     (ex.ALUSrcE),
    .JalrE       (ex.JalrE),
    .ResultSrcE  (ex.ResultSrcE),
    .ALUControlE (ex.ALUControlE),
    .funct3E     (ex.funct3E),
    .rs1_data_E  (ex.rs1_data_E),
    .rs2_data_E  (ex.rs2_data_E),
    .PCE         (ex.PCE),
    .immExtE     (ex.immExtE),
    .PCPlus4E    (ex.PCPlus4E),
    .RdE         (ex.RdE),
    .ForwardAE   (ex.ForwardAE),
    .ForwardBE   (ex.ForwardBE),
    .ResultW     (ex.ResultW),
    .PCSrcE      (ex.PCSrcE),
    .PCTargetE   (ex.PCTargetE),
    .RegWriteM   (ex.RegWriteM),
    .MemWriteM   (ex.MemWriteM),
    .ResultSrcM  (ex.ResultSrcM),
    .ALUResultM  (ex.ALUResultM),
    .WriteDataM  (ex.WriteDataM),
    .PCPlus4M    (ex.PCPlus4M),
    .RdM         (ex.RdM)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // expected M-register contents held by the model
  logic        m_regwrite, m_memwrite;
  logic [1:0]  m_resultsrc;
  logic [31:0] m_alu, m_wd, m_pc4;
  logic [4:0]  m_rd;

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] reg_v,
                                       input logic [31:0] wb_v, input logic [31:0] mem_v);
    if (sel == 2'd1) return wb_v;
    if (sel == 2'd2) return mem_v;
    return reg_v;
  endfunction

  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return a & b;
      3:  return a | b;
      4:  return a ^ b;
      5:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6:  return (a < b) ? 32'd1 : 32'd0;
      7:  return a << sh;
      8:  return a >> sh;
      9:  return $unsigned($signed(a) >>> sh);
      10: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_regwrite = 0; m_memwrite = 0; m_resultsrc = 0;
    m_alu = 0; m_wd = 0; m_pc4 = 0; m_rd = 0;
  endtask

  task automatic check_m(input string tag);
    chk({tag, ".RegWriteM"},  {31'd0, ex.RegWriteM},  {31'd0, m_regwrite});
    chk({tag, ".MemWriteM"},  {31'd0, ex.MemWriteM},  {31'd0, m_memwrite});
    chk({tag, ".ResultSrcM"}, {30'd0, ex.ResultSrcM}, {30'd0, m_resultsrc});
    chk({tag, ".ALUResultM"}, ex.ALUResultM, m_alu);
    chk({tag, ".WriteDataM"}, ex.WriteDataM, m_wd);
    chk({tag, ".PCPlus4M"},   ex.PCPlus4M,   m_pc4);
    chk({tag, ".RdM"},        {27'd0, ex.RdM}, {27'd0, m_rd});
  endtask

  // driver: inputs already set; check redirect, clock once, check M register
  task automatic step(input string tag);
    logic [31:0] a, fb, b, tgt, res;
    logic        redirect;
    #1;
    a   = pick(ex.ForwardAE, ex.rs1_data_E, ex.ResultW, m_alu);
    fb  = pick(ex.ForwardBE, ex.rs2_data_E, ex.ResultW, m_alu);
    b   = ex.ALUSrcE ? ex.immExtE : fb;
    res = ref_alu(int'(ex.ALUControlE), a, b);
    redirect = ex.JumpE || (ex.BranchE && ref_taken(ex.funct3E, a, fb));
    tgt = ex.JalrE ? ((a + ex.immExtE) & 32'hFFFF_FFFE) : (ex.PCE + ex.immExtE);
    chk({tag, ".PCSrcE"},    {31'd0, ex.PCSrcE}, {31'd0, redirect});
    chk({tag, ".PCTargetE"}, ex.PCTargetE, tgt);
    @(posedge clk);
    m_regwrite = ex.RegWriteE; m_memwrite = ex.MemWriteE; m_resultsrc = ex.ResultSrcE;
    m_alu = res; m_wd = fb; m_pc4 = ex.PCPlus4E; m_rd = ex.RdE;
    #1;
    check_m(tag);
  endtask

  task automatic clear_inputs();
    ex.RegWriteE = 0; ex.MemWriteE = 0; ex.JumpE = 0; ex.BranchE = 0;
    ex.ALUSrcE = 0; ex.JalrE = 0; ex.ResultSrcE = 0; ex.ALUControlE = 0;
    ex.funct3E = 0; ex.rs1_data_E = 0; ex.rs2_data_E = 0; ex.PCE = 0;
    ex.immExtE = 0; ex.PCPlus4E = 0; ex.RdE = 0; ex.ForwardAE = 0;
    ex.ForwardBE = 0; ex.ResultW = 0;
  endtask

  task automatic set_all_nonzero();
    ex.RegWriteE = 1; ex.MemWriteE = 1; ex.JumpE = 1; ex.BranchE = 1;
    ex.ALUSrcE = 1; ex.JalrE = 0; ex.ResultSrcE = 2'd2; ex.ALUControlE = 4'd0;
    ex.funct3E = 3'd1; ex.rs1_data_E = 32'h11; ex.rs2_data_E = 32'h22;
    ex.PCE = 32'h400; ex.immExtE = 32'h33; ex.PCPlus4E = 32'h404; ex.RdE = 5'd7;
    ex.ForwardAE = 0; ex.ForwardBE = 0; ex.ResultW = 32'h44;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    #12;
    check_m("reset");
    rst_n = 1'b1;
    #1;

    // mid-cycle asynchronous reset with busy inputs
    set_all_nonzero();
    step("pre_rst");
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_m("async_rst");
    #2 rst_n = 1'b1;
    clear_inputs();
    ex.ALUControlE = 4'd0; ex.ALUSrcE = 1; ex.rs1_data_E = 32'd5; ex.immExtE = 32'd7;
    step("rst_add");
    chk("rst_add.value", ex.ALUResultM, 32'd12);

    // forwarding from MEM then WB
    clear_inputs();
    ex.ALUControlE = 4'd10; ex.ALUSrcE = 1; ex.immExtE = 32'h10;
    step("fwd_seed");
    ex.ALUControlE = 4'd0; ex.immExtE = 32'd1; ex.rs1_data_E = 32'd1; ex.ForwardAE = 2'b10;
    step("fwd_mem");
    chk("fwd_mem.value", ex.ALUResultM, 32'h11);
    ex.ResultW = 32'h20; ex.ForwardAE = 2'b01;
    step("fwd_wb");
    chk("fwd_wb.value", ex.ALUResultM, 32'h21);

    // branches
    clear_inputs();
    ex.BranchE = 1; ex.ALUSrcE = 1; ex.rs1_data_E = 32'hFFFF_FFFF; ex.rs2_data_E = 32'd1;
    ex.PCE = 32'h100; ex.immExtE = 32'hFFFF_FFF8; ex.funct3E = 3'b100;
    step("blt");
    chk("blt.target", ex.PCTargetE, 32'hF8);
    ex.funct3E = 3'b110;
    step("bltu");
    ex.funct3E = 3'b001; ex.rs2_data_E = 32'hFFFF_FFFF;
    step("bne_eq");
    ex.funct3E = 3'b010;
    step("f3_010");

    // JALR
    clear_inputs();
    ex.JalrE = 1; ex.JumpE = 1; ex.RegWriteE = 1; ex.rs1_data_E = 32'h1003;
    ex.immExtE = 32'd2; ex.PCPlus4E = 32'h204; ex.RdE = 5'd1;
    step("jalr");
    chk("jalr.target", ex.PCTargetE, 32'h1004);

    // shifts, SLT, SUB
    clear_inputs();
    ex.ALUControlE = 4'd9; ex.rs1_data_E = 32'h8000_0000; ex.rs2_data_E = 32'h24;
    step("sra");
    chk("sra.value", ex.ALUResultM, 32'hF800_0000);
    ex.ALUControlE = 4'd5; ex.rs1_data_E = 32'hFFFF_FFFF; ex.rs2_data_E = 32'd0;
    step("slt");
    chk("slt.value", ex.ALUResultM, 32'd1);
    ex.ALUControlE = 4'd1; ex.rs1_data_E = 32'd0; ex.rs2_data_E = 32'd1;
    step("sub");
    chk("sub.value", ex.ALUResultM, 32'hFFFF_FFFF);

    // store path with forwarded store data
    clear_inputs();
    ex.ALUControlE = 4'd10; ex.ALUSrcE = 1; ex.immExtE = 32'hAB;
    step("st_seed");
    ex.ALUControlE = 4'd0; ex.MemWriteE = 1; ex.immExtE = 32'd8;
    ex.rs1_data_E = 32'h1000; ex.ForwardBE = 2'b10; ex.RdE = 5'd0;
    step("store");
    chk("store.wdata", ex.WriteDataM, 32'hAB);
    chk("store.addr", ex.ALUResultM, 32'h1008);

    // randomized traffic, including undefined ALU codes and ForwardXE=11
    for (int i = 0; i < 60; i++) begin
      ex.RegWriteE   = 1'($urandom_range(0, 1));
      ex.MemWriteE   = 1'($urandom_range(0, 1));
      ex.JumpE       = 1'($urandom_range(0, 1));
      ex.BranchE     = 1'($urandom_range(0, 1));
      ex.ALUSrcE     = 1'($urandom_range(0, 1));
      ex.JalrE       = 1'($urandom_range(0, 1));
      ex.ResultSrcE  = 2'($urandom_range(0, 3));
      ex.ALUControlE = 4'($urandom_range(0, 15));
      ex.funct3E     = 3'($urandom_range(0, 7));
      ex.rs1_data_E  = $urandom;
      ex.rs2_data_E  = ($urandom_range(0, 3) == 0) ? ex.rs1_data_E : $urandom;
      ex.PCE         = $urandom;
      ex.immExtE     = $urandom;
      ex.PCPlus4E    = ex.PCE + 32'd4;
      ex.RdE         = 5'($urandom_range(0, 31));
      ex.ForwardAE   = 2'($urandom_range(0, 3));
      ex.ForwardBE   = 2'($urandom_range(0, 3));
      ex.ResultW     = $urandom;
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
